// File: rtl/sp_ctrl_unit_pkg.sv
// Shared ISA definitions for the SP core control sequencer: opcodes, instruction fields,
// FSM state encoding and the decoded-instruction flag bundle.
package sp_ctrl_unit_pkg;

  localparam logic [3:0] OP_CLEAR    = 4'h0;
  localparam logic [3:0] OP_INC      = 4'h1;
  localparam logic [3:0] OP_ADD      = 4'h2;
  localparam logic [3:0] OP_MUL      = 4'h3;
  localparam logic [3:0] OP_MAD      = 4'h4;
  localparam logic [3:0] OP_SETP_EQ  = 4'h5;
  localparam logic [3:0] OP_SETP_LT  = 4'h6;
  localparam logic [3:0] OP_SETP_GT  = 4'h7;
  localparam logic [3:0] OP_SETP_NEQ = 4'h8;
  localparam logic [3:0] OP_CORE_ID  = 4'h9;
  localparam logic [3:0] OP_N_CORES  = 4'hA;
  localparam logic [3:0] OP_BRP      = 4'hB;
  localparam logic [3:0] OP_JMP      = 4'hC;
  localparam logic [3:0] OP_NOP      = 4'hD;
  localparam logic [3:0] OP_RSVD     = 4'hE;
  localparam logic [3:0] OP_HALT     = 4'hF;

  // ALU_C value that freezes P and ALU_OUT
  localparam logic [3:0] ALU_HOLD = 4'hF;

  localparam int OPC_LSB = 12;
  localparam int A_LSB   = 8;
  localparam int B_LSB   = 4;
  localparam int C_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  typedef struct packed {
    logic is_alu;
    logic writes_back;
    logic is_branch;
    logic is_jump;
    logic is_halt;
  } dec_t;

  function automatic logic [3:0] ir_field(input logic [15:0] ir, input int lsb);
    return ir[lsb +: 4];
  endfunction

endpackage

// File: rtl/sp_ctrl_unit_if.sv
// Instruction-memory fetch handshake plus ALU/register-file control lines of one SP core.
// master = control sequencer, slave = instruction memory + datapath.
interface sp_ctrl_unit_if #(
  parameter int PC_W = 8
);
  logic            IMEM_REQ;
  logic [PC_W-1:0] IMEM_ADDR;
  logic            IMEM_VALID;
  logic [15:0]     IMEM_DATA;
  logic            P;
  logic [3:0]      ALU_C;
  logic [3:0]      A_SEL;
  logic [3:0]      B_SEL;
  logic [3:0]      C_SEL;
  logic            REG_WE;

  modport master (
    output IMEM_REQ, IMEM_ADDR, ALU_C, A_SEL, B_SEL, C_SEL, REG_WE,
    input  IMEM_VALID, IMEM_DATA, P
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR, ALU_C, A_SEL, B_SEL, C_SEL, REG_WE,
    output IMEM_VALID, IMEM_DATA, P
  );
endinterface

// File: rtl/sp_ctrl_unit_decoder.sv
// Combinational opcode classifier for the control sequencer.
module sp_ctrl_unit_decoder
  import sp_ctrl_unit_pkg::*;
(
  input  logic [3:0] opcode_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OP_CLEAR, OP_INC, OP_ADD, OP_MUL, OP_MAD, OP_CORE_ID, OP_N_CORES: begin
        dec_o.is_alu      = 1'b1;
        dec_o.writes_back = 1'b1;
      end
      // predicate setters update P only, never the register file
      OP_SETP_EQ, OP_SETP_LT, OP_SETP_GT, OP_SETP_NEQ: dec_o.is_alu = 1'b1;
      OP_BRP:          dec_o.is_branch = 1'b1;
      OP_JMP:          dec_o.is_jump   = 1'b1;
      OP_HALT:         dec_o.is_halt   = 1'b1;
      OP_NOP, OP_RSVD: ;
    endcase
  end

endmodule

// File: rtl/sp_ctrl_unit.sv
// Per-SP-core control sequencer: fetch / decode / execute FSM owning PC and IR, driving ALU_C,
// operand selects and register write-enable, and resolving BRP from the ALU predicate.
module sp_ctrl_unit
  import sp_ctrl_unit_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic START,
  output logic BUSY,
  output logic DONE,
  sp_ctrl_unit_if.master bus
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [15:0]     ir_q;
  logic            req_q;
  logic [3:0]      alu_c_q;
  logic            we_q;
  logic            busy_q;
  logic            done_q;
  dec_t            dec;

  sp_ctrl_unit_decoder u_dec (
    .opcode_i (ir_field(ir_q, OPC_LSB)),
    .dec_o    (dec)
  );

  // Branch target is the low PC_W bits of IR; P is taken as seen during EXEC
  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (dec.is_jump || (dec.is_branch && bus.P))
      pc_d = ir_q[PC_W-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      req_q   <= 1'b0;
      alu_c_q <= ALU_HOLD;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      alu_c_q <= ALU_HOLD;
      we_q    <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (START) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (bus.IMEM_VALID) begin
            ir_q    <= bus.IMEM_DATA;
            req_q   <= 1'b0;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_q <= ST_EXEC;
          if (dec.is_alu)
            alu_c_q <= ir_field(ir_q, OPC_LSB);
          we_q <= dec.writes_back;
        end
        ST_EXEC: begin
          pc_q <= pc_d;
          if (dec.is_halt) begin
            state_q <= ST_HALT;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Selects follow IR, which only changes on a completed fetch, so they hold between instructions
  assign bus.A_SEL     = ir_field(ir_q, A_LSB);
  assign bus.B_SEL     = ir_field(ir_q, B_LSB);
  assign bus.C_SEL     = ir_field(ir_q, C_LSB);
  assign bus.IMEM_REQ  = req_q;
  assign bus.IMEM_ADDR = pc_q;
  assign bus.ALU_C     = alu_c_q;
  assign bus.REG_WE    = we_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;

endmodule

// File: tb/tb_sp_ctrl_unit.sv
// Directed-vector bench for sp_ctrl_unit with hand-computed expectations.
module tb_sp_ctrl_unit;

  localparam int PC_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  sp_ctrl_unit_if #(.PC_W(PC_W)) bus ();

  sp_ctrl_unit #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .START (start),
    .BUSY  (busy),
    .DONE  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] d_a, d_b, d_c, d_aluc, x_aluc;
  logic       d_we, x_we;

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Starts at a FETCH negedge, returns at the negedge after EXEC
  task automatic issue(input logic [15:0] instr, input logic p);
    bus.IMEM_VALID = 1'b1;
    bus.IMEM_DATA  = instr;
    bus.P          = p;
    step();
    bus.IMEM_VALID = 1'b0;
    d_a    = bus.A_SEL;
    d_b    = bus.B_SEL;
    d_c    = bus.C_SEL;
    d_aluc = bus.ALU_C;
    d_we   = bus.REG_WE;
    step();
    x_aluc = bus.ALU_C;
    x_we   = bus.REG_WE;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    bus.IMEM_VALID = 1'b0;
    bus.IMEM_DATA  = 16'h0000;
    bus.P          = 1'b0;
    step();
    step();
    check_vec("rst_req",   32'(bus.IMEM_REQ),  32'h0);
    check_vec("rst_addr",  32'(bus.IMEM_ADDR), 32'h00);
    check_vec("rst_aluc",  32'(bus.ALU_C),     32'hF);
    check_vec("rst_asel",  32'(bus.A_SEL),     32'h0);
    check_vec("rst_we",    32'(bus.REG_WE),    32'h0);
    check_vec("rst_busy",  32'(busy),          32'h0);
    check_vec("rst_done",  32'(done),          32'h0);
    rst_n = 1'b1;
    step();
    check_vec("idle_req",  32'(bus.IMEM_REQ),  32'h0);

    // ADD a=1,b=2,c=3
    start = 1'b1;
    step();
    start = 1'b0;
    check_vec("t1_req",    32'(bus.IMEM_REQ),  32'h1);
    check_vec("t1_addr",   32'(bus.IMEM_ADDR), 32'h00);
    check_vec("t1_busy",   32'(busy),          32'h1);
    issue(16'h2123, 1'b0);
    check_vec("t1_dsel",   32'({d_a, d_b, d_c}), 32'h123);
    check_vec("t1_daluc",  32'(d_aluc),        32'hF);
    check_vec("t1_dwe",    32'(d_we),          32'h0);
    check_vec("t1_xaluc",  32'(x_aluc),        32'h2);
    check_vec("t1_xwe",    32'(x_we),          32'h1);
    check_vec("t1_nwe",    32'(bus.REG_WE),    32'h0);
    check_vec("t1_naluc",  32'(bus.ALU_C),     32'hF);
    check_vec("t1_naddr",  32'(bus.IMEM_ADDR), 32'h01);
    check_vec("t1_nreq",   32'(bus.IMEM_REQ),  32'h1);

    // SETP LT then BRP, taken then not taken
    issue(16'h6120, 1'b1);
    check_vec("t2_setp_aluc", 32'(x_aluc),     32'h6);
    check_vec("t2_setp_we",   32'(x_we),       32'h0);
    check_vec("t2_setp_addr", 32'(bus.IMEM_ADDR), 32'h02);
    issue(16'hB005, 1'b1);
    check_vec("t2_brp_daluc", 32'(d_aluc),     32'hF);
    check_vec("t2_brp_xaluc", 32'(x_aluc),     32'hF);
    check_vec("t2_brp_we",    32'(x_we),       32'h0);
    check_vec("t2_taken",     32'(bus.IMEM_ADDR), 32'h05);
    issue(16'h6120, 1'b0);
    check_vec("t2_setp2_addr", 32'(bus.IMEM_ADDR), 32'h06);
    issue(16'hB005, 1'b0);
    check_vec("t2_brp2_xaluc", 32'(x_aluc),    32'hF);
    check_vec("t2_not_taken", 32'(bus.IMEM_ADDR), 32'h07);

    // Delayed IMEM_VALID; stray VALID in DECODE/EXEC
    for (int i = 0; i < 4; i++) begin
      check_vec("t3_wait_req",  32'(bus.IMEM_REQ),  32'h1);
      check_vec("t3_wait_addr", 32'(bus.IMEM_ADDR), 32'h07);
      check_vec("t3_wait_aluc", 32'(bus.ALU_C),     32'hF);
      step();
    end
    check_vec("t3_req5",  32'(bus.IMEM_REQ),  32'h1);
    check_vec("t3_addr5", 32'(bus.IMEM_ADDR), 32'h07);
    bus.IMEM_VALID = 1'b1;
    bus.IMEM_DATA  = 16'hD456;
    step();
    bus.IMEM_DATA  = 16'hF000;
    check_vec("t3_dsel",  32'({bus.A_SEL, bus.B_SEL, bus.C_SEL}), 32'h456);
    check_vec("t3_dreq",  32'(bus.IMEM_REQ),  32'h0);
    step();
    step();
    bus.IMEM_VALID = 1'b0;
    check_vec("t3_keep_sel", 32'(bus.A_SEL),  32'h4);
    check_vec("t3_addr8",    32'(bus.IMEM_ADDR), 32'h08);
    check_vec("t3_nodone",   32'(done),       32'h0);
    step();
    check_vec("t3_still_req", 32'(bus.IMEM_REQ), 32'h1);
    check_vec("t3_still_sel", 32'(bus.A_SEL),    32'h4);

    // PC wrap
    issue(16'hC0FF, 1'b0);
    check_vec("t4_jmp",  32'(bus.IMEM_ADDR), 32'hFF);
    issue(16'hD000, 1'b0);
    check_vec("t4_wrap", 32'(bus.IMEM_ADDR), 32'h00);

    // HALT with START held the whole time
    start = 1'b1;
    issue(16'hF000, 1'b0);
    check_vec("t5_xaluc", 32'(x_aluc),       32'hF);
    check_vec("t5_done",  32'(done),         32'h1);
    check_vec("t5_busy",  32'(busy),         32'h0);
    check_vec("t5_req",   32'(bus.IMEM_REQ), 32'h0);
    step();
    start = 1'b0;
    check_vec("t5_rs_addr", 32'(bus.IMEM_ADDR), 32'h00);
    check_vec("t5_rs_done", 32'(done),         32'h0);
    check_vec("t5_rs_busy", 32'(busy),         32'h1);
    check_vec("t5_rs_req",  32'(bus.IMEM_REQ), 32'h1);

    // Reset mid-FETCH with a late VALID
    issue(16'hD123, 1'b0);
    check_vec("t6_pre_addr", 32'(bus.IMEM_ADDR), 32'h01);
    #2 rst_n = 1'b0;
    #1;
    check_vec("t6f_req",  32'(bus.IMEM_REQ),  32'h0);
    check_vec("t6f_addr", 32'(bus.IMEM_ADDR), 32'h00);
    check_vec("t6f_busy", 32'(busy),          32'h0);
    check_vec("t6f_asel", 32'(bus.A_SEL),     32'h0);
    bus.IMEM_VALID = 1'b1;
    bus.IMEM_DATA  = 16'h2123;
    step();
    rst_n = 1'b1;
    step();
    bus.IMEM_VALID = 1'b0;
    check_vec("t6f_idle_busy", 32'(busy),      32'h0);
    check_vec("t6f_idle_sel",  32'(bus.A_SEL), 32'h0);
    check_vec("t6f_idle_req",  32'(bus.IMEM_REQ), 32'h0);

    // Reset mid-EXEC of a write-back op
    start = 1'b1;
    step();
    start = 1'b0;
    check_vec("t6_restart_req", 32'(bus.IMEM_REQ), 32'h1);
    issue(16'hD000, 1'b0);
    bus.IMEM_VALID = 1'b1;
    bus.IMEM_DATA  = 16'h2123;
    step();
    bus.IMEM_VALID = 1'b0;
    step();
    check_vec("t6e_we_pre", 32'(bus.REG_WE), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_vec("t6e_we",   32'(bus.REG_WE),    32'h0);
    check_vec("t6e_aluc", 32'(bus.ALU_C),     32'hF);
    check_vec("t6e_addr", 32'(bus.IMEM_ADDR), 32'h00);
    check_vec("t6e_busy", 32'(busy),          32'h0);
    step();
    rst_n = 1'b1;
    step();
    check_vec("t6e_idle_addr", 32'(bus.IMEM_ADDR), 32'h00);
    check_vec("t6e_idle_busy", 32'(busy),          32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    issue(16'h2123, 1'b0);
    check_vec("t6_resume_aluc", 32'(x_aluc),        32'h2);
    check_vec("t6_resume_we",   32'(x_we),          32'h1);
    check_vec("t6_resume_addr", 32'(bus.IMEM_ADDR), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
